lsu_mem_stage: RTL and testbench

//  Memory-stage load/store unit; produces read_data_m and the stall for the MEM/WB pipeline register.

---
 rtl/lsu_mem_stage.sv | 176 +++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: req/gnt/rvalid handshake to data memory, store lane steering,
// load alignment/extension and pipeline stall. Optional misaligned-access trap: MISALIGN_TRAP_EN.
module lsu_mem_stage #(
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_read_m,
  input  logic                     mem_write_m,
  input  logic [2:0]               funct3_m,
  input  logic [ADDRESS_WIDTH-1:0] alu_result_m,
  input  logic [DATA_WIDTH-1:0]    write_data_m,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [ADDRESS_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]    dmem_wdata,
  output logic [3:0]               dmem_be,
  input  logic                     dmem_gnt,
  input  logic                     dmem_rvalid,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata,
  output logic [DATA_WIDTH-1:0]    read_data_m,
  output logic                     stall_m,
  output logic                     bus_err_m
);

  localparam int unsigned TIMER_W = 8;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  state_t                   state, state_n;
  logic [TIMER_W-1:0]       timer;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [3:0]               be_q;
  logic [2:0]               f3_q;
  logic [1:0]               off_q;
  logic                     we_q;

  logic                     op_c;
  logic [1:0]               a_c;
  logic [3:0]               be_c;
  logic [DATA_WIDTH-1:0]    wdata_c;
  logic [7:0]               byte_c;
  logic [15:0]              half_c;
  logic [DATA_WIDTH-1:0]    load_c;
  logic                     timeout_c;
  logic                     trap_c;
  logic                     misalign_c;

  assign op_c = mem_read_m | mem_write_m;
  assign a_c  = alu_result_m[1:0];

  // Store lane steering from the live MEM-stage operands
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = write_data_m;
    case (funct3_m[1:0])
      2'b00: begin
        be_c    = 4'(4'b0001 << a_c);
        wdata_c = {4{write_data_m[7:0]}};
      end
      2'b01: begin
        be_c    = a_c[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{write_data_m[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign misalign_c = ((funct3_m[1:0] == 2'b01) && a_c[0]) ||
                      ((funct3_m[1:0] == 2'b10) && (a_c != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  // Load alignment and extension using the latched offset/size
  always_comb begin
    case (off_q)
      2'd0:    byte_c = dmem_rdata[7:0];
      2'd1:    byte_c = dmem_rdata[15:8];
      2'd2:    byte_c = dmem_rdata[23:16];
      default: byte_c = dmem_rdata[31:24];
    endcase
    half_c = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q)
      3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
      3'b100:  load_c = {24'd0, byte_c};
      3'b001:  load_c = {{16{half_c[15]}}, half_c};
      3'b101:  load_c = {16'd0, half_c};
      default: load_c = dmem_rdata;
    endcase
  end

  // Next state and stall; stall rises in S_IDLE the same cycle an op is presented
  always_comb begin
    state_n   = state;
    stall_m   = 1'b0;
    timeout_c = 1'b0;
    trap_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (op_c) begin
          stall_m = 1'b1;
          if (misalign_c) begin
            state_n = S_DONE;
            trap_c  = 1'b1;
          end else begin
            state_n = S_REQ;
          end
        end
      end
      S_REQ: begin
        stall_m = 1'b1;
        if (dmem_gnt) state_n = we_q ? S_DONE : S_RESP;
      end
      S_RESP: begin
        stall_m = 1'b1;
        if (dmem_rvalid) begin
          state_n = S_DONE;
        end else if (timer == TIMER_LAST) begin
          state_n   = S_DONE;
          timeout_c = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      read_data_m <= '0;
      bus_err_m   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      we_q        <= 1'b0;
    end else begin
      state     <= state_n;
      bus_err_m <= timeout_c | trap_c;
      if (state == S_IDLE && op_c) begin
        addr_q  <= {alu_result_m[ADDRESS_WIDTH-1:2], 2'b00};
        wdata_q <= wdata_c;
        be_q    <= be_c;
        f3_q    <= funct3_m;
        off_q   <= a_c;
        we_q    <= mem_write_m;
      end
      if (state != S_RESP && state_n == S_RESP) begin
        timer <= '0;
      end else if (state == S_RESP && timer != TIMER_MAX) begin
        timer <= timer + TIMER_W'(1);
      end
      if (state == S_RESP && dmem_rvalid) begin
        read_data_m <= load_c;
      end else if (timeout_c || trap_c) begin
        read_data_m <= '0;
      end
    end
  end

  assign dmem_req   = (state == S_REQ);
  assign dmem_we    = dmem_req & we_q;
  assign dmem_be    = dmem_req ? be_q : 4'b0000;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed table-driven bench for lsu_mem_stage plus a reset-during-response sequence.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_m, mem_write_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m, write_data_m;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] read_data_m;
  logic        stall_m, bus_err_m;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_mem_stage dut (
    .clk(clk), .rst(rst),
    .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
    .funct3_m(funct3_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .read_data_m(read_data_m), .stall_m(stall_m), .bus_err_m(bus_err_m)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gd;
    logic        resp;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    int          exp_req;
    int          exp_stall;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t v[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run(input int idx, input vec_t t);
    int   stall_n  = 0;
    int   req_n    = 0;
    int   cyc      = 0;
    logic gnt_prev = 1'b0;
    logic done     = 1'b0;
    @(negedge clk);
    mem_read_m   = t.rd;
    mem_write_m  = t.wr;
    funct3_m     = t.f3;
    alu_result_m = t.addr;
    write_data_m = t.wdata;
    dmem_rdata   = t.rdata;
    while (!done && cyc < 400) begin
      #1;
      if (stall_m) stall_n++;
      else done = 1'b1;
      if (dmem_req) begin
        req_n++;
        chk($sformatf("v%0d addr", idx), dmem_addr, t.exp_addr);
        chk($sformatf("v%0d we", idx), 32'(dmem_we), 32'(t.wr));
        if (t.wr) begin
          chk($sformatf("v%0d be", idx), 32'(dmem_be), 32'(t.exp_be));
          chk($sformatf("v%0d wdata", idx), dmem_wdata, t.exp_wdata);
        end
      end
      dmem_rvalid = gnt_prev && t.rd && t.resp;
      dmem_gnt    = dmem_req && (req_n > t.gd);
      gnt_prev    = dmem_gnt;
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) chk($sformatf("v%0d completion", idx), 32'd0, 32'd1);
    chk($sformatf("v%0d stall_cycles", idx), 32'(stall_n), 32'(t.exp_stall));
    chk($sformatf("v%0d req_cycles", idx), 32'(req_n), 32'(t.exp_req));
    chk($sformatf("v%0d bus_err", idx), 32'(bus_err_m), 32'(t.exp_err));
    mem_read_m  = 1'b0;
    mem_write_m = 1'b0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    #1;
    chk($sformatf("v%0d read_data", idx), read_data_m, t.exp_rd);
    chk($sformatf("v%0d bus_err_clear", idx), 32'(bus_err_m), 32'd0);
  endtask

  initial begin
    //        rd    wr    f3      addr          wdata         rdata        gd resp  exp_addr      be       exp_wdata   req stall err   exp_rd
    v[0]  = '{1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 1'b1, 32'h100, 4'b1111, 32'hDEADBEEF, 1, 2,  1'b0, 32'h0};
    v[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 0, 1'b1, 32'h100, 4'b0000, 32'h0,        1, 3,  1'b0, 32'hFFFFFF80};
    v[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 0, 1'b1, 32'h100, 4'b0000, 32'h0,        1, 3,  1'b0, 32'h00000080};
    v[3]  = '{1'b0, 1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0,        0, 1'b1, 32'h100, 4'b1100, 32'h12341234, 1, 2,  1'b0, 32'h00000080};
    v[4]  = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0,        32'hABCD0000, 0, 1'b1, 32'h100, 4'b0000, 32'h0,        1, 3,  1'b0, 32'h0000ABCD};
    v[5]  = '{1'b1, 1'b0, 3'b001, 32'h100, 32'h0,        32'h00008001, 0, 1'b1, 32'h100, 4'b0000, 32'h0,        1, 3,  1'b0, 32'hFFFF8001};
    v[6]  = '{1'b0, 1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0,        0, 1'b1, 32'h100, 4'b0010, 32'hA5A5A5A5, 1, 2,  1'b0, 32'hFFFF8001};
    v[7]  = '{1'b1, 1'b0, 3'b010, 32'h204, 32'h0,        32'h12345678, 3, 1'b1, 32'h204, 4'b0000, 32'h0,        4, 6,  1'b0, 32'h12345678};
    v[8]  = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 0, 1'b1, 32'h100, 4'b0000, 32'h0,        1, 3,  1'b0, 32'h0000007F};
`ifdef MISALIGN_TRAP_EN
    v[9]  = '{1'b1, 1'b0, 3'b010, 32'h101, 32'h0,        32'hCAFEF00D, 0, 1'b1, 32'h100, 4'b0000, 32'h0,        0, 1,  1'b1, 32'h0};
`else
    v[9]  = '{1'b1, 1'b0, 3'b010, 32'h101, 32'h0,        32'hCAFEF00D, 0, 1'b1, 32'h100, 4'b0000, 32'h0,        1, 3,  1'b0, 32'hCAFEF00D};
`endif
    v[10] = '{1'b1, 1'b0, 3'b010, 32'h300, 32'h0,        32'h0,        0, 1'b0, 32'h300, 4'b0000, 32'h0,        1, 257, 1'b1, 32'h0};
    v[11] = '{1'b0, 1'b1, 3'b000, 32'h102, 32'h00000011, 32'h0,        0, 1'b1, 32'h100, 4'b0100, 32'h11111111, 1, 2,  1'b0, 32'h0};
    v[12] = '{1'b1, 1'b0, 3'b100, 32'h100, 32'h0,        32'h000000AB, 0, 1'b1, 32'h100, 4'b0000, 32'h0,        1, 3,  1'b0, 32'h000000AB};

    rst          = 1'b1;
    mem_read_m   = 1'b0;
    mem_write_m  = 1'b0;
    funct3_m     = 3'b000;
    alu_result_m = '0;
    write_data_m = '0;
    dmem_gnt     = 1'b0;
    dmem_rvalid  = 1'b0;
    dmem_rdata   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset req", 32'(dmem_req), 32'd0);
    chk("reset be", 32'(dmem_be), 32'd0);
    chk("reset we", 32'(dmem_we), 32'd0);
    chk("reset stall", 32'(stall_m), 32'd0);
    chk("reset bus_err", 32'(bus_err_m), 32'd0);
    chk("reset read_data", read_data_m, 32'd0);

    for (int i = 0; i < 13; i++) run(i, v[i]);

    // Reset while waiting in S_RESP, with a late response right after
    @(negedge clk);
    mem_read_m   = 1'b1;
    funct3_m     = 3'b010;
    alu_result_m = 32'h400;
    dmem_rdata   = 32'h55555555;
    #1;
    chk("rst_seq idle stall", 32'(stall_m), 32'd1);
    @(negedge clk);
    #1;
    chk("rst_seq req", 32'(dmem_req), 32'd1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    #1;
    chk("rst_seq resp stall", 32'(stall_m), 32'd1);
    rst        = 1'b1;
    mem_read_m = 1'b0;
    @(negedge clk);
    rst         = 1'b0;
    dmem_rvalid = 1'b1;
    #1;
    chk("rst_seq stall", 32'(stall_m), 32'd0);
    chk("rst_seq read_data", read_data_m, 32'd0);
    chk("rst_seq req_after", 32'(dmem_req), 32'd0);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    chk("rst_seq rvalid ignored", read_data_m, 32'd0);
    chk("rst_seq stall_after", 32'(stall_m), 32'd0);
    chk("rst_seq bus_err", 32'(bus_err_m), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
